// File: rtl/sampler_pkg.sv
// Shared types, note-start table and keycode map for the polyphonic sampler voice allocator.
// Optional looping playback is selected elsewhere with the SAMPLER_LOOP_EN macro; LOOP_OFS lives here.
package sampler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        RELEASE
    } voice_state_t;

    typedef enum logic {
        ACCEPT,
        APPLY
    } event_state_t;

    localparam int NUM_NOTES = 12;

    localparam logic [19:0] NOTE_START [NUM_NOTES] = '{
        20'h008C0, 20'h089C0, 20'h102B0, 20'h183A0,
        20'h20540, 20'h28638, 20'h30750, 20'h388A0,
        20'h409C0, 20'h48B08, 20'h50C58, 20'h58D50
    };

    localparam logic [7:0] KEY_CODES [NUM_NOTES] = '{
        8'd43, 8'd20, 8'd26, 8'd8, 8'd21, 8'd23,
        8'd28, 8'd24, 8'd12, 8'd18, 8'd19, 8'd47
    };

    localparam logic [19:0] LOOP_OFS = 20'h02000;

    typedef struct packed {
        logic        valid;
        logic [19:0] start;
    } note_lookup_t;

    function automatic note_lookup_t lookupNote(input logic [7:0] code);
        note_lookup_t res;
        res = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (!res.valid && code == KEY_CODES[i]) begin
                res.valid = 1'b1;
                res.start = NOTE_START[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sampler_voice.sv
// One playback voice: state, sample address counter, release divider and gain.
// With SAMPLER_LOOP_EN defined a held note wraps to start+LOOP_OFS instead of ending.
module sampler_voice
    import sampler_pkg::*;
#(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] NOTE_LEN = 20'h08000,
    parameter int                GAIN_W   = 4,
    parameter int                REL_DIV  = 256
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               tick_i,
    input  logic               load_i,
    input  logic [ADDR_W-1:0]  loadAddr_i,
    input  logic [7:0]         loadKey_i,
    input  logic               release_i,
    output voice_state_t       state_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [GAIN_W-1:0]  gain_o,
    output logic [7:0]         key_o
);

`ifdef SAMPLER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int DIV_W = (REL_DIV > 1) ? $clog2(REL_DIV) : 1;

    voice_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [7:0]        key_q, key_d;

    logic [ADDR_W-1:0] endAddr;
    logic              atEnd;
    logic              divWrap;

    assign endAddr = start_q + NOTE_LEN - ADDR_W'(1);
    assign atEnd   = (addr_q == endAddr);
    assign divWrap = (div_q == DIV_W'(REL_DIV - 1));

    // A load (press or retrigger) overrides any tick or end-of-region on this voice.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start_d = start_q;
        gain_d  = gain_q;
        div_d   = div_q;
        key_d   = key_q;
        if (load_i) begin
            state_d = PLAY;
            addr_d  = loadAddr_i;
            start_d = loadAddr_i;
            gain_d  = '1;
            div_d   = '0;
            key_d   = loadKey_i;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (tick_i) begin
                        if (!atEnd) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else if (LOOP_EN) begin
                            addr_d = start_q + ADDR_W'(LOOP_OFS);
                        end else begin
                            state_d = IDLE;
                            gain_d  = '0;
                        end
                    end
                    if (release_i && state_d == PLAY) begin
                        state_d = RELEASE;
                        div_d   = '0;
                    end
                end
                RELEASE: begin
                    if (tick_i) begin
                        if (atEnd) begin
                            state_d = IDLE;
                            gain_d  = '0;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (divWrap) begin
                                div_d  = '0;
                                gain_d = gain_q - GAIN_W'(1);
                                if (gain_q == GAIN_W'(1)) begin
                                    state_d = IDLE;
                                end
                            end else begin
                                div_d = div_q + DIV_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            start_q <= '0;
            gain_q  <= '0;
            div_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            gain_q  <= gain_d;
            div_q   <= div_d;
            key_q   <= key_d;
        end
    end

    assign state_o = state_q;
    assign addr_o  = addr_q;
    assign gain_o  = gain_q;
    assign key_o   = key_q;

endmodule

// File: rtl/sampler_voice_allocator.sv
// Polyphonic keymapper: accepts key events, maps them to note addresses and allocates voices.
// Looping playback in the voices is enabled by defining SAMPLER_LOOP_EN.
module sampler_voice_allocator
    import sampler_pkg::*;
#(
    parameter int                NUM_VOICES  = 4,
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] NOTE_LEN    = 20'h08000,
    parameter int                BANK_W      = 2,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = 20'h60000,
    parameter int                GAIN_W      = 4,
    parameter int                REL_DIV     = 256
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         key_valid,
    output logic                         key_ready,
    input  logic [7:0]                   key_code,
    input  logic                         key_down,
    input  logic [BANK_W-1:0]            bank_sel,
    input  logic                         sample_tick,
    output logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*GAIN_W-1:0] voice_gain,
    output logic                         invalid_note,
    output logic                         voice_stolen
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    event_state_t      evt_q, evt_d;
    logic [7:0]        keyCode_q, keyCode_d;
    logic              keyDown_q, keyDown_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [IDX_W-1:0]  stealPtr_q, stealPtr_d;
    logic              invalid_q, invalid_d;
    logic              stolen_q, stolen_d;

    voice_state_t      voiceState [NUM_VOICES];
    logic [7:0]        voiceKey   [NUM_VOICES];
    logic [ADDR_W-1:0] voiceAddr  [NUM_VOICES];
    logic [GAIN_W-1:0] voiceGain  [NUM_VOICES];
    logic [NUM_VOICES-1:0] loadVec, relVec;

    note_lookup_t      note;
    logic [ADDR_W-1:0] startAddr;
    logic              hitFound, idleFound, relFound;
    logic [IDX_W-1:0]  hitIdx, idleIdx, relIdx;

    assign note      = lookupNote(keyCode_q);
    assign startAddr = ADDR_W'(note.start) + ADDR_W'(bank_q) * BANK_STRIDE;

    // Retrigger beats a free voice, which beats round-robin stealing.
    always_comb begin
        evt_d      = evt_q;
        keyCode_d  = keyCode_q;
        keyDown_d  = keyDown_q;
        bank_d     = bank_q;
        stealPtr_d = stealPtr_q;
        invalid_d  = 1'b0;
        stolen_d   = 1'b0;
        loadVec    = '0;
        relVec     = '0;
        hitFound   = 1'b0;
        hitIdx     = '0;
        idleFound  = 1'b0;
        idleIdx    = '0;
        relFound   = 1'b0;
        relIdx     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hitFound && voiceState[i] != IDLE && voiceKey[i] == keyCode_q) begin
                hitFound = 1'b1;
                hitIdx   = IDX_W'(i);
            end
            if (!idleFound && voiceState[i] == IDLE) begin
                idleFound = 1'b1;
                idleIdx   = IDX_W'(i);
            end
            if (!relFound && voiceState[i] == PLAY && voiceKey[i] == keyCode_q) begin
                relFound = 1'b1;
                relIdx   = IDX_W'(i);
            end
        end
        unique case (evt_q)
            ACCEPT: begin
                if (key_valid) begin
                    keyCode_d = key_code;
                    keyDown_d = key_down;
                    bank_d    = bank_sel;
                    evt_d     = APPLY;
                end
            end
            APPLY: begin
                evt_d = ACCEPT;
                if (!note.valid) begin
                    invalid_d = 1'b1;
                end else if (keyDown_q) begin
                    if (hitFound) begin
                        loadVec[hitIdx] = 1'b1;
                    end else if (idleFound) begin
                        loadVec[idleIdx] = 1'b1;
                    end else begin
                        loadVec[stealPtr_q] = 1'b1;
                        stolen_d            = 1'b1;
                        stealPtr_d = (stealPtr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : stealPtr_q + IDX_W'(1);
                    end
                end else if (relFound) begin
                    relVec[relIdx] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            evt_q      <= ACCEPT;
            keyCode_q  <= '0;
            keyDown_q  <= 1'b0;
            bank_q     <= '0;
            stealPtr_q <= '0;
            invalid_q  <= 1'b0;
            stolen_q   <= 1'b0;
        end else begin
            evt_q      <= evt_d;
            keyCode_q  <= keyCode_d;
            keyDown_q  <= keyDown_d;
            bank_q     <= bank_d;
            stealPtr_q <= stealPtr_d;
            invalid_q  <= invalid_d;
            stolen_q   <= stolen_d;
        end
    end

    assign key_ready    = (evt_q == ACCEPT);
    assign invalid_note = invalid_q;
    assign voice_stolen = stolen_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : gVoice
        sampler_voice #(
            .ADDR_W  (ADDR_W),
            .NOTE_LEN(NOTE_LEN),
            .GAIN_W  (GAIN_W),
            .REL_DIV (REL_DIV)
        ) uVoice (
            .clk_i     (Clk),
            .rst_ni    (Reset_n),
            .tick_i    (sample_tick),
            .load_i    (loadVec[g]),
            .loadAddr_i(startAddr),
            .loadKey_i (keyCode_q),
            .release_i (relVec[g]),
            .state_o   (voiceState[g]),
            .addr_o    (voiceAddr[g]),
            .gain_o    (voiceGain[g]),
            .key_o     (voiceKey[g])
        );
        assign voice_addr[g*ADDR_W +: ADDR_W] = voiceAddr[g];
        assign voice_gain[g*GAIN_W +: GAIN_W] = voiceGain[g];
        assign voice_active[g]                = (voiceState[g] != IDLE);
    end

endmodule

// File: tb/tb_sampler_voice_allocator.sv
// Directed self-checking bench for sampler_voice_allocator (default 4 voices, 20-bit addresses).
// Expectations for region end follow SAMPLER_LOOP_EN when it is defined for the build.
module tb_sampler_voice_allocator;

    logic        Clk;
    logic        Reset_n;
    logic        key_valid;
    logic        key_ready;
    logic [7:0]  key_code;
    logic        key_down;
    logic [1:0]  bank_sel;
    logic        sample_tick;
    logic [79:0] voice_addr;
    logic [3:0]  voice_active;
    logic [15:0] voice_gain;
    logic        invalid_note;
    logic        voice_stolen;

    int checkCount;
    int errorCount;
    logic sawInvalid;
    logic sawStolen;
    logic sawReady;

    sampler_voice_allocator dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_down    (key_down),
        .bank_sel    (bank_sel),
        .sample_tick (sample_tick),
        .voice_addr  (voice_addr),
        .voice_active(voice_active),
        .voice_gain  (voice_gain),
        .invalid_note(invalid_note),
        .voice_stolen(voice_stolen)
    );

    // 100 MHz free-running clock; the design acts on the rising edge.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [19:0] vAddr(input int i);
        return voice_addr[i*20 +: 20];
    endfunction

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic doReset();
        Reset_n     = 1'b0;
        key_valid   = 1'b0;
        key_code    = '0;
        key_down    = 1'b0;
        bank_sel    = '0;
        sample_tick = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Called on a falling edge; returns on the falling edge after APPLY has completed.
    task automatic applyStimulus(input logic [7:0] code, input logic down, input logic [1:0] bank,
                                 input logic tickAtApply);
        int n;
        n = 0;
        while (!key_ready && n < 8) begin
            @(negedge Clk);
            n++;
        end
        if (!key_ready) checkOutput("readyTimeout", 80'(key_ready), 80'd1);
        key_valid = 1'b1;
        key_code  = code;
        key_down  = down;
        bank_sel  = bank;
        @(negedge Clk);
        key_valid   = 1'b0;
        sample_tick = tickAtApply;
        @(negedge Clk);
        sample_tick = 1'b0;
        sawInvalid  = invalid_note;
        sawStolen   = voice_stolen;
        sawReady    = key_ready;
    endtask

    task automatic tickN(input int n);
        repeat (n) begin
            sample_tick = 1'b1;
            @(negedge Clk);
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        $display("[TB] starting sampler_voice_allocator bench");

        doReset();
        checkOutput("rstAddr", voice_addr, 80'd0);
        checkOutput("rstActive", 80'(voice_active), 80'd0);
        checkOutput("rstGain", 80'(voice_gain), 80'd0);
        checkOutput("rstReady", 80'(key_ready), 80'd1);
        checkOutput("rstInvalid", 80'(invalid_note), 80'd0);
        checkOutput("rstStolen", 80'(voice_stolen), 80'd0);

        // Single press and stepping
        applyStimulus(8'd43, 1'b1, 2'd0, 1'b0);
        checkOutput("pressActive", 80'(voice_active), 80'h1);
        checkOutput("pressAddr", 80'(vAddr(0)), 80'h008C0);
        checkOutput("pressGain", 80'(voice_gain), 80'h000F);
        tickN(3);
        checkOutput("tick3Addr", 80'(vAddr(0)), 80'h008C3);
        checkOutput("tick3Active", 80'(voice_active), 80'h1);

        // Fill all voices, then steal voice 0
        doReset();
        applyStimulus(8'd43, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'd20, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'd26, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'd8,  1'b1, 2'd0, 1'b0);
        checkOutput("fillStolen", 80'(sawStolen), 80'd0);
        checkOutput("fillActive", 80'(voice_active), 80'hF);
        applyStimulus(8'd21, 1'b1, 2'd0, 1'b0);
        checkOutput("stealPulse", 80'(sawStolen), 80'd1);
        checkOutput("stealAddrs", voice_addr, {20'h183A0, 20'h102B0, 20'h089C0, 20'h20540});
        @(negedge Clk);
        checkOutput("stealPulseEnd", 80'(voice_stolen), 80'd0);

        // Unmapped keycode leaves voices alone
        applyStimulus(8'd99, 1'b1, 2'd0, 1'b0);
        checkOutput("invalidPulse", 80'(sawInvalid), 80'd1);
        checkOutput("invalidReady", 80'(sawReady), 80'd1);
        checkOutput("invalidAddrs", voice_addr, {20'h183A0, 20'h102B0, 20'h089C0, 20'h20540});
        @(negedge Clk);
        checkOutput("invalidPulseEnd", 80'(invalid_note), 80'd0);

        // Bank 3 wraps modulo 2^20; steal pointer has moved to voice 1
        applyStimulus(8'd43, 1'b1, 2'd3, 1'b0);
        checkOutput("bank3Stolen", 80'(sawStolen), 80'd1);
        checkOutput("bank3Addr", 80'(vAddr(1)), 80'h208C0);

        // Release envelope
        doReset();
        applyStimulus(8'd26, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'd26, 1'b0, 2'd0, 1'b0);
        checkOutput("relActive", 80'(voice_active), 80'h1);
        tickN(255);
        checkOutput("rel255Gain", 80'(voice_gain), 80'h000F);
        checkOutput("rel255Addr", 80'(vAddr(0)), 80'h103AF);
        tickN(1);
        checkOutput("rel256Gain", 80'(voice_gain), 80'h000E);
        checkOutput("rel256Addr", 80'(vAddr(0)), 80'h103B0);
        tickN(3584);
        checkOutput("relEndGain", 80'(voice_gain), 80'h0000);
        checkOutput("relEndActive", 80'(voice_active), 80'h0);

        // Allocation coincident with a tick, then retrigger
        doReset();
        applyStimulus(8'd43, 1'b1, 2'd0, 1'b0);
        applyStimulus(8'd18, 1'b1, 2'd1, 1'b1);
        checkOutput("tickAllocAddr", 80'(vAddr(1)), 80'hA8B08);
        checkOutput("tickOtherAddr", 80'(vAddr(0)), 80'h008C1);
        tickN(2);
        checkOutput("tickAllocStep", 80'(vAddr(1)), 80'hA8B0A);
        applyStimulus(8'd18, 1'b1, 2'd0, 1'b0);
        checkOutput("retrigAddr", 80'(vAddr(1)), 80'h48B08);
        checkOutput("retrigActive", 80'(voice_active), 80'h3);
        checkOutput("retrigStolen", 80'(sawStolen), 80'd0);

        // Hold key 47 to the end of its region
        doReset();
        applyStimulus(8'd47, 1'b1, 2'd0, 1'b0);
        tickN(32767);
        checkOutput("lastAddr", 80'(vAddr(0)), 80'h60D4F);
        checkOutput("lastActive", 80'(voice_active), 80'h1);
        tickN(1);
`ifdef SAMPLER_LOOP_EN
        checkOutput("endAddr", 80'(vAddr(0)), 80'h5AD50);
        checkOutput("endActive", 80'(voice_active), 80'h1);
`else
        checkOutput("endAddr", 80'(vAddr(0)), 80'h60D4F);
        checkOutput("endActive", 80'(voice_active), 80'h0);
        checkOutput("endGain", 80'(voice_gain), 80'h0000);
`endif

        // Asynchronous reset in the middle of playback
        applyStimulus(8'd43, 1'b1, 2'd0, 1'b0);
        tickN(2);
`ifdef SAMPLER_LOOP_EN
        checkOutput("preRstActive", 80'(voice_active), 80'h3);
`else
        checkOutput("preRstActive", 80'(voice_active), 80'h1);
`endif
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("asyncAddr", voice_addr, 80'd0);
        checkOutput("asyncActive", 80'(voice_active), 80'd0);
        checkOutput("asyncGain", 80'(voice_gain), 80'd0);
        checkOutput("asyncReady", 80'(key_ready), 80'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
